nibble_serial_adder: RTL

- Multi-cycle WIDTH-bit add/subtract engine built on one 4-bit ripple-carry adder (rca4).
- Feeds one nibble per cycle, least-significant first, and registers the carry between nibbles.
- Accepts operands through a valid/ready handshake and returns the result through a valid/ready handshake.
- Sits between the operand source (register file / ALU front end) and any consumer that tolerates multi-cycle latency, trading area for WIDTH/4 cycles of latency.

---
 rtl/adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_if.sv | 26 ++
 rtl/nibble_serial_adder_rca4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 92 +++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between the operand source and the serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, busy
    );
endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// Four-bit ripple-carry adder used as the single shared datapath slice.
module rca4
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);
    logic [NIB_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIB_W];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per cycle through a shared rca4, LSB first.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NNIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             overflow_q;

    logic [NIB_W-1:0] sum;
    logic             rca_cout;

    rca4 u_rca4 (
        .a    (a_reg[NIB_W*idx +: NIB_W]),
        .b    (b_reg[NIB_W*idx +: NIB_W]),
        .cin  (carry_reg),
        .sum  (sum),
        .cout (rca_cout)
    );

    // Subtract is folded in at capture time: b is stored inverted and the +1 rides in on carry_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result_q[NIB_W*idx +: NIB_W] <= sum;
                    carry_reg                    <= rca_cout;
                    if (idx == LAST) begin
                        idx        <= '0;
                        cout_q     <= rca_cout;
                        overflow_q <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                      (sum[NIB_W-1] != a_reg[WIDTH-1]);
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
endmodule
